// File: rtl/ddr_pkg.sv
// Shared DDR controller definitions: FSM encoding, default timing and the
// burst-length normalisation used by both the read and write paths.
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CL = 2'd1,
        CAPTURE = 2'd2
    } ddr_state_t;

    localparam int BURST_LENGTH_DEF = 16;
    localparam int CAS_LATENCY_DEF  = 3;
    localparam int BEAT_W           = 16;

    // Zero or oversize requests mean a full burst; odd lengths round up so
    // the transfer always ends on a complete rise/fall pair.
    function automatic int norm_len(input int req, input int burst);
        int len;
        if (req == 0 || req > burst)
            len = burst;
        else
            len = req + (req & 1);
        return len;
    endfunction

endpackage

// File: rtl/ddr_read_capture.sv
// DDR read-data return path: waits out CAS latency after a READ, packs the
// rise/fall beat pairs into one wide word and pulses DATA_VALID when complete.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no read outstanding; RD_CMD accepted here
//  WAIT_CL | READ issued, counting down the remaining CAS latency
//  CAPTURE | one rise/fall pair written into DATA_OUT per cycle
module ddr_read_capture
    import ddr_pkg::*;
#(
    parameter int BURST_LENGTH = BURST_LENGTH_DEF,
    parameter int CAS_LATENCY  = CAS_LATENCY_DEF,
    parameter int LEN_W        = 5
) (
    input  logic                           SYS_CLK_100M,
    input  logic                           RST_N,
    input  logic                           RD_CMD,
    input  logic [LEN_W-1:0]               READ_LENGTH,
    input  logic [BEAT_W-1:0]              DQ_RISE,
    input  logic [BEAT_W-1:0]              DQ_FALL,
    input  logic [1:0]                     DQS_RISE,
    output logic [BEAT_W*BURST_LENGTH-1:0] DATA_OUT,
    output logic                           DATA_VALID,
    output logic                           BUSY,
    output logic                           CMD_DROP,
    output logic                           DQS_ERR
);

    localparam int PAIR_W = $clog2(BURST_LENGTH);
    localparam int LAT_W  = (CAS_LATENCY > 2) ? $clog2(CAS_LATENCY - 1) : 1;
    // Cycle T is the RD_CMD cycle itself, so WAIT_CL only covers CL-1 cycles.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((CAS_LATENCY > 1) ? CAS_LATENCY - 2 : 0);

    ddr_state_t        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [PAIR_W-1:0] pair_idx;
    logic [PAIR_W-1:0] last_pair;
    logic [LEN_W:0]    len_eff;
    logic [LEN_W:0]    pair_cnt;

    always_comb begin
        len_eff  = (LEN_W+1)'(norm_len(int'(READ_LENGTH), BURST_LENGTH));
        pair_cnt = len_eff >> 1;
    end

    always_ff @(posedge SYS_CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            pair_idx   <= '0;
            last_pair  <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            CMD_DROP   <= 1'b0;
            DQS_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            CMD_DROP   <= RD_CMD && BUSY;

            case (state)
                IDLE: begin
                    if (RD_CMD) begin
                        last_pair <= PAIR_W'(pair_cnt - (LEN_W+1)'(1));
                        pair_idx  <= '0;
                        DQS_ERR   <= 1'b0;
                        DATA_OUT  <= '0;
                        BUSY      <= 1'b1;
                        if (CAS_LATENCY == 1) begin
                            state <= CAPTURE;
                        end else begin
                            state   <= WAIT_CL;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                end

                WAIT_CL: begin
                    if (lat_cnt == '0)
                        state <= CAPTURE;
                    else
                        lat_cnt <= lat_cnt - 1'b1;
                end

                CAPTURE: begin
                    DATA_OUT[pair_idx*2*BEAT_W +: 2*BEAT_W] <= {DQ_FALL, DQ_RISE};
                    if (DQS_RISE != 2'b11)
                        DQS_ERR <= 1'b1;
                    if (pair_idx == last_pair) begin
                        state      <= IDLE;
                        DATA_VALID <= 1'b1;
                        BUSY       <= 1'b0;
                    end else begin
                        pair_idx <= pair_idx + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_capture.sv
// Directed bench for ddr_read_capture: table of read lengths plus hand-written
// sequences for dropped commands, back-to-back reads, strobe errors and reset.
module tb_ddr_read_capture;

    localparam int BL = 16;
    localparam int CL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_cmd = 1'b0;
    logic [4:0]    read_length = '0;
    logic [15:0]   dq_rise = '0;
    logic [15:0]   dq_fall = '0;
    logic [1:0]    dqs_rise = 2'b11;
    logic [255:0]  data_out;
    logic          data_valid, busy, cmd_drop, dqs_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_read_capture #(.BURST_LENGTH(BL), .CAS_LATENCY(CL), .LEN_W(5)) dut (
        .SYS_CLK_100M (clk),
        .RST_N        (rst_n),
        .RD_CMD       (rd_cmd),
        .READ_LENGTH  (read_length),
        .DQ_RISE      (dq_rise),
        .DQ_FALL      (dq_fall),
        .DQS_RISE     (dqs_rise),
        .DATA_OUT     (data_out),
        .DATA_VALID   (data_valid),
        .BUSY         (busy),
        .CMD_DROP     (cmd_drop),
        .DQS_ERR      (dqs_err)
    );

    typedef struct {
        logic [4:0] len;
        int         exp_pairs;
        int         exp_lat;
        int         seed;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int p, input int seed);
        if (seed == 0 && p == 0) return 32'h76543210;
        if (seed == 0 && p == 1) return 32'hFEDCBA98;
        return 32'(32'h9E3779B9 * (p + 1) + seed * 32'h01010101);
    endfunction

    // Issues RD_CMD in the current cycle and plays the beats from T+CL onward,
    // checking every cycle until DATA_VALID or the cycle budget runs out.
    task automatic do_read(input logic [4:0] len, input int exp_pairs, input int exp_lat,
                           input int bad_pair, input bit drop, input int seed,
                           output logic [255:0] exp_data);
        int  lat;
        int  p;
        int  j;
        bit  err_exp;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            rd_cmd      = (k == 0) || (drop && k == 4);
            read_length = (k == 0) ? len : 5'd2;
            if (k >= CL && k - CL < 8) begin
                p = k - CL;
                {dq_fall, dq_rise} = pat(p, seed);
                dqs_rise = (p == bad_pair) ? 2'b01 : 2'b11;
            end else begin
                dq_rise  = 16'hDEAD;
                dq_fall  = 16'hBEEF;
                dqs_rise = 2'b00;
            end
            step();
            j = k + 1;
            check("cmd_drop", 256'(cmd_drop), 256'(drop && j == 5));
            err_exp = (bad_pair >= 0) && (bad_pair < exp_pairs) && (j >= CL + bad_pair + 1);
            check("dqs_err", 256'(dqs_err), 256'(err_exp));
            if (data_valid) begin
                lat = j;
                break;
            end
            check("busy", 256'(busy), 256'(1));
        end
        rd_cmd   = 1'b0;
        dqs_rise = 2'b11;
        check("latency", 256'(lat), 256'(exp_lat));
        check("busy_at_valid", 256'(busy), 256'(0));
        exp_data = '0;
        for (int q = 0; q < exp_pairs; q++)
            exp_data[q*32 +: 32] = pat(q, seed);
        check("data_out", data_out, exp_data);
    endtask

    initial begin
        logic [255:0] exp_d;
        int           vcount;

        vecs[0] = '{5'd16, 8, 11, 0};
        vecs[1] = '{5'd5,  3, 6,  1};
        vecs[2] = '{5'd0,  8, 11, 2};
        vecs[3] = '{5'd20, 8, 11, 3};
        vecs[4] = '{5'd1,  1, 4,  4};
        vecs[5] = '{5'd15, 8, 11, 5};
        vecs[6] = '{5'd8,  4, 7,  6};
        vecs[7] = '{5'd2,  1, 4,  7};

        #12;
        check("rst_data_out", data_out, '0);
        check("rst_flags", 256'({data_valid, busy, cmd_drop, dqs_err}), 256'(0));
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 8; i++) begin
            do_read(vecs[i].len, vecs[i].exp_pairs, vecs[i].exp_lat, -1, 1'b0, vecs[i].seed, exp_d);
            if (i == 0)
                check("full_low64", 256'(data_out[63:0]), 256'(64'hFEDCBA98_76543210));
            if (i == 1)
                check("short_upper_zero", 256'(data_out[255:96]), 256'(0));
            step();
            check("valid_pulse", 256'(data_valid), 256'(0));
            check("data_hold", data_out, exp_d);
        end

        // Dropped command mid-read, then a new read issued in the DATA_VALID cycle.
        do_read(5'd16, 8, 11, -1, 1'b1, 11, exp_d);
        do_read(5'd16, 8, 11, -1, 1'b0, 12, exp_d);
        step();
        check("cmd_drop_idle", 256'(cmd_drop), 256'(0));

        // Strobe error on pair 2 is sticky past DATA_VALID, cleared by the next read.
        do_read(5'd16, 8, 11, 2, 1'b0, 13, exp_d);
        step();
        check("dqs_err_held", 256'(dqs_err), 256'(1));
        do_read(5'd4, 2, 5, -1, 1'b0, 14, exp_d);
        step();

        // Reset in the middle of a full read.
        rd_cmd      = 1'b1;
        read_length = 5'd16;
        step();
        rd_cmd   = 1'b0;
        dqs_rise = 2'b11;
        for (int k = 1; k < 5; k++) begin
            {dq_fall, dq_rise} = pat(k, 21);
            step();
        end
        check("pre_rst_busy", 256'(busy), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data_out", data_out, '0);
        check("midrst_flags", 256'({data_valid, busy, cmd_drop, dqs_err}), 256'(0));
        step();
        rst_n = 1'b1;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (data_valid) vcount++;
        end
        check("no_valid_after_rst", 256'(vcount), 256'(0));
        do_read(5'd16, 8, 11, -1, 1'b0, 22, exp_d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/ddr_read_capture.md
Name: ddr_read_capture

Overview:
- Read-data return path of the DDR SDRAM controller: the receiving end of the burst that the write path drives onto DATA_RAM/DQS.
- After the controller issues a READ command, this block waits the CAS latency, then captures DDR beats already split by the IO cells into rising/falling 16-bit halves.
- It packs the beats into one wide word, with beat 0 in the low bits, the same packing as the write-side DATA_IN.
- It signals completion to the user side with a one-cycle DATA_VALID pulse.

Parameters:
- BURST_LENGTH, 16, maximum 16-bit beats per read; even, 2..16.
- CAS_LATENCY, 3, SYS_CLK_100M cycles from RD_CMD sample to first capture; ≥1.
- LEN_W, 5, width of READ_LENGTH.

Ports:
- SYS_CLK_100M  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RD_CMD  in  1  one-cycle pulse, coincident with the READ command issued to the RAM.
- READ_LENGTH  in  LEN_W  number of 16-bit beats requested; sampled with RD_CMD.
- DQ_RISE  in  16  DQ captured on the DQS rising edge (even beat).
- DQ_FALL  in  16  DQ captured on the DQS falling edge (odd beat).
- DQS_RISE  in  2  per-byte DQS level sampled at the rising capture.
- DATA_OUT  out  16*BURST_LENGTH  assembled burst; beat k at [16k+15:16k].
- DATA_VALID  out  1  one-cycle pulse; DATA_OUT is complete.
- BUSY  out  1  read in progress; RD_CMD is not accepted while high.
- CMD_DROP  out  1  one-cycle pulse; RD_CMD arrived while BUSY.
- DQS_ERR  out  1  sticky strobe error for the current or last read.

Behaviour:
- Reset, async on RST_N low: state IDLE; DATA_OUT=0, DATA_VALID=0, BUSY=0, CMD_DROP=0, DQS_ERR=0; latency and beat counters 0. RST_N low mid-read aborts the read with no DATA_VALID.
- States: IDLE, WAIT_CL, CAPTURE.
- IDLE with RD_CMD=1 at cycle T:
  - Latch the effective length L.
  - Clear DQS_ERR.
  - Zero all of DATA_OUT.
  - BUSY=1 from T+1.
  - Go to WAIT_CL, or straight to CAPTURE if CAS_LATENCY=1.
- Length rule, computed in LEN_W+1 bits:
  - READ_LENGTH=0 or >BURST_LENGTH gives L=BURST_LENGTH.
  - Odd values round up to the next even.
  - Pairs to capture N=L/2.
- WAIT_CL: counts down so the first capture edge is T+CAS_LATENCY.
- CAPTURE, cycles T+CL .. T+CL+N-1, pair index p=0..N-1:
  - DATA_OUT[32p+15:32p] ← DQ_RISE.
  - DATA_OUT[32p+31:32p+16] ← DQ_FALL.
  - If DQS_RISE≠2'b11, set DQS_ERR.
  - Words at index ≥L stay 0.
- After the last pair, return to IDLE. Cycle T+CL+N: DATA_VALID=1 and BUSY=0 (registered, same edge).
- Back-to-back reads: RD_CMD is legal in the DATA_VALID cycle and is accepted normally. DATA_OUT is cleared on the following edge, so the consumer must take DATA_OUT in the DATA_VALID cycle.
- RD_CMD while BUSY=1: ignored. CMD_DROP=1 on the next cycle; the current read is unaffected.
- DATA_OUT holds its value between reads. DQS_ERR holds until the next accepted RD_CMD.
- Total latency from RD_CMD to DATA_VALID: CAS_LATENCY+N cycles. Default full burst: 3+8=11.

Decomposition:
- Shared package ddr_pkg:
  - State encoding (IDLE/WAIT_CL/CAPTURE).
  - BURST_LENGTH and CAS_LATENCY defaults.
  - Beat width constant 16.
  - Length-normalisation function, shared with the write path's WRITE_LENGTH handling.
- No sub-module: the packer is an indexed write into DATA_OUT inside the single FSM block.

Test Plan:
- Reset mid-read (RST_N low at T+5 of a full read) → all outputs 0 immediately, no DATA_VALID, next RD_CMD works normally.
- RD_CMD, READ_LENGTH=16, beats 0x3210,0x7654,0xBA98,0xFEDC,... (pattern 32'h76543210,32'hFEDCBA98,... per pair), DQS_RISE=2'b11 → DATA_VALID at T+11, DATA_OUT[63:0]=64'hFEDCBA98_76543210, BUSY high T+1..T+10, DQS_ERR=0.
- READ_LENGTH=5 → L=6, 3 captures, DATA_VALID at T+6, DATA_OUT[255:96]=0.
- READ_LENGTH=0 and READ_LENGTH=20 → both behave as L=16, DATA_VALID at T+11.
- Second RD_CMD at T+4 during a read → CMD_DROP pulse at T+5, first read completes unchanged. RD_CMD in the DATA_VALID cycle → accepted, next DATA_VALID 11 cycles later.
- DQS_RISE=2'b01 on pair 2 of a read → DQS_ERR=1 from T+6, held after DATA_VALID, cleared on next accepted RD_CMD.
